lut_eval_cgrundey: RTL and testbench
====================================

Name: lut_eval_cgrundey

Overview:
- Programmable N-input boolean function unit: a 2^N_IN-entry truth table is indexed by the input variables and produces a registered 1-bit result.
- Generalises the fixed 4-input mux-implemented function into a parametrised, run-time reloadable block.
- The truth table is loaded serially through a shadow register and committed atomically, so evaluation is never disturbed by a partial load.
- Sits between the variable-producing datapath and any consumer of a registered boolean result.

Parameters:
- N_IN, 4, number of input variables; legal range 1..8; table depth TBL = 2^N_IN.
- INIT_TABLE, 16'h4A5B, active-table reset value; width TBL; bit k = f for in_vars == k.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  output enable; 0 forces a result of 0
- in_valid  input  1  in_vars valid this cycle
- in_vars  input  N_IN  function variables; MSB is the first variable
- f  output  1  registered function result
- out_valid  output  1  f valid
- load_start  input  1  begin (or restart) a table load
- load_valid  input  1  load_bit valid this cycle
- load_bit  input  1  serial table bit, entry 0 first
- load_busy  output  1  load in progress (LOAD or COMMIT)
- load_done  output  1  one-cycle pulse: new table active

Behaviour:
- Reset, sampled on the clk edge while reset=1:
  - active table <= INIT_TABLE; shadow <= 0; bit count <= 0; state <= IDLE.
  - f, out_valid, load_busy and load_done all <= 0.
  - Reset mid-load discards the partial load; the table returns to INIT_TABLE.
- Evaluation, 1-cycle latency:
  - At each edge: out_valid <= in_valid.
  - If in_valid: f <= en ? active[in_vars] : 0.
  - If in_valid=0: f holds its value. Downstream samples f only when out_valid=1.
  - Accepts back-to-back inputs every cycle; there is no backpressure.
- Load FSM, states IDLE, LOAD, COMMIT:
  - IDLE: load_start=1 -> LOAD, count <= 0. load_valid is ignored in IDLE.
  - LOAD, each cycle with load_valid=1: shadow[count] <= load_bit and count <= count+1.
  - LOAD, load_valid=1 with count == TBL-1: the bit is stored and the FSM moves to COMMIT.
  - LOAD, load_start=1: restart with count <= 0. The shadow is not cleared. A load_bit presented in the same cycle is discarded. load_start has priority over load_valid.
  - COMMIT, one cycle: at the exiting edge active <= shadow, load_done <= 1 (high for exactly the following cycle), state <= IDLE.
  - load_start during COMMIT is ignored; it must be reissued from IDLE.
- load_busy = 1 in LOAD and COMMIT, 0 in IDLE; it is a registered state decode.
- Commit/evaluate ordering:
  - An evaluation sampled at the COMMIT-exit edge uses the old table.
  - Evaluation sampled at any later edge uses the new table.
  - The active table never holds a mix of old and new bits.
- count width is N_IN+1 bits and never exceeds TBL-1 while in LOAD.
- A load_valid gap of any length inside LOAD simply stalls the load; there is no timeout.
- en is sampled together with in_vars; changing en does not affect loads.

Test Plan:
- Reset defaults: release reset, apply in_vars 0..15 with en=1 back-to-back -> f = bits of 16'h4A5B one cycle later: 1,1,0,1,1,0,1,0,0,1,0,1,0,0,1,0. out_valid=1 for 16 consecutive cycles.
- Enable gating: en=0, in_vars=4'h0 with in_valid=1 -> f=0, out_valid=1. en=1 on the same input -> f=1.
- Full load: load_start, then 16 bits of 16'hFFFF with gaps of 0-3 idle cycles between them -> load_busy high from the cycle after load_start until load_done. load_done pulses once. Afterwards every in_vars gives f=1.
- Atomic commit: stream evaluations of in_vars=4'h2 continuously through a 16'hFFFF load -> f=0 up to and including the sample at the COMMIT-exit edge, then f=1. No glitch value ever appears.
- Restart: load 7 bits, then load_start, then 16 bits of 16'h0001 -> the table becomes 16'h0001 (f=1 only for in_vars=0). Exactly one load_done pulse.
- Reset mid-load: after 9 load bits assert reset for one cycle -> load_busy=0, out_valid=0, and the table is 16'h4A5B. Subsequent load_valid pulses without load_start are ignored.

Source files
------------

// File: rtl/lut_eval_cgrundey.sv
// Programmable N_IN-input boolean function unit.
// A 2^N_IN-entry truth table is indexed by in_vars and gives a registered 1-bit result f.
// Each new table is shifted serially into a shadow register, entry 0 first.
// It is then committed to the active table in a single cycle.
// Evaluation therefore never sees a partially loaded table.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   en                  output enable; 0 forces f to 0 for the sampled input
//   in_valid, in_vars   evaluation request and function variables
//   f, out_valid        registered result, one cycle after in_valid
//   load_start          begin or restart a table load
//   load_valid/load_bit serial table bit, entry 0 first
//   load_busy           load in progress (LOAD or COMMIT)
//   load_done           one-cycle pulse when the new table becomes active
module lut_eval_cgrundey #(
    parameter int unsigned               N_IN       = 4,
    parameter logic [(2**N_IN)-1:0]      INIT_TABLE = 16'h4A5B
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_vars,
    output logic            f,
    output logic            out_valid,
    input  logic            load_start,
    input  logic            load_valid,
    input  logic            load_bit,
    output logic            load_busy,
    output logic            load_done
);

    localparam int unsigned    TBL      = 2 ** N_IN;
    localparam logic [N_IN:0]  CNT_LAST = (N_IN + 1)'(TBL - 1);
    localparam logic [N_IN:0]  CNT_ONE  = (N_IN + 1)'(1);

    typedef enum logic [1:0] {StIdle, StLoad, StCommit} state_e;

    state_e          state_q, state_d;
    logic [TBL-1:0]  active_q, active_d;
    logic [TBL-1:0]  shadow_q, shadow_d;
    logic [N_IN:0]   count_q, count_d;
    logic            f_q, f_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            active_q    <= INIT_TABLE;
            shadow_q    <= '0;
            count_q     <= '0;
            f_q         <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            count_q     <= count_d;
            f_q         <= f_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Load FSM next state
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        active_d = active_q;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d = StLoad;
                    count_d = '0;
                end
            end
            StLoad: begin
                // A restart discards any bit presented in the same cycle
                if (load_start) begin
                    count_d = '0;
                end else if (load_valid) begin
                    shadow_d[count_q[N_IN-1:0]] = load_bit;
                    if (count_q == CNT_LAST) begin
                        state_d = StCommit;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
            end
            StCommit: begin
                active_d = shadow_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs. f is computed from active_q, so a sample taken on the commit edge
    // still uses the old table.
    always_comb begin
        out_valid_d = in_valid;
        f_d         = f_q;
        if (in_valid) begin
            f_d = en ? active_q[in_vars] : 1'b0;
        end
        busy_d = (state_d != StIdle);
        done_d = (state_q == StCommit);
    end

    assign f         = f_q;
    assign out_valid = out_valid_q;
    assign load_busy = busy_q;
    assign load_done = done_q;

endmodule

// File: tb/tb_lut_eval_cgrundey.sv
module tb_lut_eval_cgrundey;

    localparam logic [15:0] INIT = 16'h4A5B;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_vars = '0;
    logic       f;
    logic       out_valid;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_bit = 1'b0;
    logic       load_busy;
    logic       load_done;

    int checks = 0;
    int failures = 0;

    // Reference model: a truth table, a pending new table and a load position
    logic [15:0] m_table = INIT;
    logic [15:0] m_shadow = '0;
    int          m_pos = 0;
    bit          m_loading = 1'b0;
    bit          m_pending = 1'b0;
    logic        exp_f = 1'b0;
    logic        exp_ov = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_busy = 1'b0;
    bit          rnd_eval = 1'b0;

    lut_eval_cgrundey #(
        .N_IN       (4),
        .INIT_TABLE (INIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .in_valid   (in_valid),
        .in_vars    (in_vars),
        .f          (f),
        .out_valid  (out_valid),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_bit   (load_bit),
        .load_busy  (load_busy),
        .load_done  (load_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: update the model from the inputs at the edge, then compare
    task automatic tick();
        if (rnd_eval) begin
            in_valid = 1'($urandom_range(0, 1));
            en       = ($urandom_range(0, 3) != 0);
            in_vars  = 4'($urandom_range(0, 15));
        end
        if (reset) begin
            m_table = INIT; m_shadow = '0; m_pos = 0;
            m_loading = 1'b0; m_pending = 1'b0;
            exp_f = 1'b0; exp_ov = 1'b0; exp_done = 1'b0;
        end else begin
            exp_ov = in_valid;
            if (in_valid) exp_f = en ? m_table[in_vars] : 1'b0;
            exp_done = m_pending;
            if (m_pending) begin
                m_table   = m_shadow;
                m_pending = 1'b0;
            end else if (m_loading) begin
                if (load_start) begin
                    m_pos = 0;
                end else if (load_valid) begin
                    m_shadow[m_pos] = load_bit;
                    m_pos++;
                    if (m_pos == 16) begin
                        m_loading = 1'b0;
                        m_pending = 1'b1;
                    end
                end
            end else if (load_start) begin
                m_loading = 1'b1;
                m_pos     = 0;
            end
        end
        exp_busy = m_loading || m_pending;
        @(posedge clk);
        #1;
        chk("f", f, exp_f);
        chk("out_valid", out_valid, exp_ov);
        chk("load_busy", load_busy, exp_busy);
        chk("load_done", load_done, exp_done);
    endtask

    task automatic send_bit(input logic b, input int gap);
        load_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        load_valid = 1'b1;
        load_bit   = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic load_table(input logic [15:0] t, input int max_gap);
        for (int k = 0; k < 16; k++) send_bit(t[k], $urandom_range(0, max_gap));
    endtask

    task automatic sweep(input logic e);
        rnd_eval = 1'b0;
        en       = e;
        in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_vars = 4'(k);
            tick();
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        logic [15:0] rt;
        int          dones;

        // Reset defaults
        tick();
        tick();
        reset = 1'b0;
        tick();
        sweep(1'b1);

        // Enable gating on entry 0 (INIT bit 0 is 1)
        in_valid = 1'b1;
        in_vars  = 4'h0;
        en       = 1'b0;
        tick();
        chk("gate_en0", f, 1'b0);
        en = 1'b1;
        tick();
        chk("gate_en1", f, 1'b1);

        // Full all-ones load while evaluating entry 2 (old value 0) every cycle
        in_vars = 4'h2;
        start_load();
        load_table(16'hFFFF, 3);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (load_done) dones++;
        end
        checks++;
        assert (dones == 1) else begin
            failures++;
            $error("FAIL done_count_full observed=%0d expected=1", dones);
        end
        sweep(1'b1);

        // Restart: 7 bits, then restart with a discarded bit, then 16'h0001
        start_load();
        for (int k = 0; k < 7; k++) send_bit(1'($urandom_range(0, 1)), 0);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_bit   = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        rnd_eval   = 1'b1;
        load_table(16'h0001, 2);
        for (int i = 0; i < 4; i++) tick();
        sweep(1'b1);

        // Random tables with random evaluation traffic
        for (int r = 0; r < 3; r++) begin
            rt       = 16'($urandom());
            rnd_eval = 1'b1;
            start_load();
            load_table(rt, 2);
            for (int i = 0; i < 6; i++) tick();
            sweep(1'b1);
        end

        // Reset mid-load, then stray load bits without load_start
        rnd_eval = 1'b1;
        start_load();
        for (int k = 0; k < 9; k++) send_bit(1'($urandom_range(0, 1)), 1);
        rnd_eval = 1'b0;
        in_valid = 1'b1;
        reset    = 1'b1;
        tick();
        chk("rst_mid_busy", load_busy, 1'b0);
        chk("rst_mid_ov", out_valid, 1'b0);
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) send_bit(1'b1, 0);
        sweep(1'b1);
        sweep(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
